// File: rtl/game_pkg.sv
// Shared screen/objective codes and on-screen button geometry
// for the game flow controller and its click decoder.
package game_pkg;

  typedef enum logic [3:0] {
    ST_TITLE  = 4'd0,
    ST_STAFF  = 4'd1,
    ST_STAGE1 = 4'd2,
    ST_SUCC1  = 4'd3,
    ST_STAGE2 = 4'd4,
    ST_SUCC2  = 4'd5,
    ST_STAGE3 = 4'd6,
    ST_SUCC3  = 4'd7,
    ST_FAIL   = 4'd8,
    ST_HELP   = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    TD_NONE  = 2'd0,
    TD_KEY   = 2'd1,
    TD_LIGHT = 2'd2,
    TD_DOOR  = 2'd3
  } todo_e;

  localparam int B_NONE   = 0;
  localparam int B_STAGE1 = 1;
  localparam int B_STAGE2 = 2;
  localparam int B_STAGE3 = 3;
  localparam int B_HELP   = 4;
  localparam int B_NEXT   = 5;
  localparam int B_BACK   = 6;
  localparam int B_RETRY  = 7;

  localparam logic [8:0] BTN_X0 = 9'd120;
  localparam logic [8:0] BTN_X1 = 9'd200;
  localparam logic [8:0] BTN_H  = 9'd20;

  localparam logic [8:0] Y_T_S1     = 9'd120;
  localparam logic [8:0] Y_T_S2     = 9'd150;
  localparam logic [8:0] Y_T_S3     = 9'd180;
  localparam logic [8:0] Y_T_HELP   = 9'd210;
  localparam logic [8:0] Y_H_BACK   = 9'd200;
  localparam logic [8:0] Y_ST_BACK  = 9'd180;
  localparam logic [8:0] Y_SU_NEXT  = 9'd140;
  localparam logic [8:0] Y_SU_BACK  = 9'd180;
  localparam logic [8:0] Y_SU3_NEXT = 9'd150;
  localparam logic [8:0] Y_F_RETRY  = 9'd140;
  localparam logic [8:0] Y_F_BACK   = 9'd180;

  localparam logic [1:0] LIFE_INIT = 2'd3;

  function automatic logic in_btn(
    input logic [8:0] x,
    input logic [8:0] y,
    input logic [8:0] y0
  );
    return (x >= BTN_X0) && (x < BTN_X1) &&
           (y >= y0) && (y < y0 + BTN_H);
  endfunction

  function automatic logic is_stage(input state_e s);
    return (s == ST_STAGE1) || (s == ST_STAGE2) ||
           (s == ST_STAGE3);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_decode.sv
// Click-to-button decoder: one-hot button id for the current screen,
// B_NONE when the click lands on no active button.
module ui_button_decode
  import game_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [8:0] click_x_i,
  input  logic [8:0] click_y_i,
  input  logic [3:0] play_valid_i,
  output logic [7:0] btn_o
);

  logic [7:0] hit;

  always_comb begin
    hit = '0;
    case (state_i)
      ST_TITLE: begin
        if (in_btn(click_x_i, click_y_i, Y_T_S1))
          hit[B_STAGE1] = 1'b1;
        else if (in_btn(click_x_i, click_y_i, Y_T_S2))
          hit[B_STAGE2] = play_valid_i[2];
        else if (in_btn(click_x_i, click_y_i, Y_T_S3))
          hit[B_STAGE3] = play_valid_i[3];
        else if (in_btn(click_x_i, click_y_i, Y_T_HELP))
          hit[B_HELP] = 1'b1;
      end
      ST_HELP:
        hit[B_BACK] = in_btn(click_x_i, click_y_i, Y_H_BACK);
      ST_STAFF:
        hit[B_BACK] = in_btn(click_x_i, click_y_i, Y_ST_BACK);
      ST_SUCC1, ST_SUCC2: begin
        hit[B_NEXT] = in_btn(click_x_i, click_y_i, Y_SU_NEXT);
        hit[B_BACK] = in_btn(click_x_i, click_y_i, Y_SU_BACK);
      end
      ST_SUCC3:
        hit[B_NEXT] = in_btn(click_x_i, click_y_i, Y_SU3_NEXT);
      ST_FAIL: begin
        hit[B_RETRY] = in_btn(click_x_i, click_y_i, Y_F_RETRY);
        hit[B_BACK]  = in_btn(click_x_i, click_y_i, Y_F_BACK);
      end
      default: hit = '0;
    endcase
    btn_o = hit;
    if (hit == '0)
      btn_o[B_NONE] = 1'b1;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Screen sequencer and in-stage objective tracker driving the
// UI overlay renderer; every output is registered.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int CLICK_GUARD  = 10_000_000,
  parameter int HIT_COOLDOWN = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       click,
  input  logic [8:0] click_x,
  input  logic [8:0] click_y,
  input  logic       key_pick,
  input  logic       light_on,
  input  logic       at_door,
  input  logic       hit,
  input  logic       abort,
  output logic [3:0] state,
  output logic [1:0] key_find,
  output logic [1:0] life,
  output logic [1:0] todo,
  output logic [3:0] play_valid
);

  state_e           state_q, state_d, last_q, last_d;
  todo_e            todo_q, todo_d;
  logic [1:0]       key_q, key_d, life_q, life_d;
  logic [3:0]       pv_q, pv_d;
  logic [CNT_W-1:0] guard_q, guard_d, cool_q, cool_d;
  logic [7:0]       btn;

  ui_button_decode u_dec (
    .state_i      (state_q),
    .click_x_i    (click_x),
    .click_y_i    (click_y),
    .play_valid_i (pv_q),
    .btn_o        (btn)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    todo_d  = todo_q;
    key_d   = key_q;
    life_d  = life_q;
    pv_d    = pv_q;
    guard_d = (guard_q != '0) ? guard_q - 1'b1 : '0;
    cool_d  = (cool_q != '0) ? cool_q - 1'b1 : '0;
    if (is_stage(state_q)) begin
      if (abort) begin
        state_d = ST_TITLE;
      end else if (at_door && todo_q == TD_DOOR) begin
        state_d = state_e'(state_q + 4'd1);
        if (state_q == ST_STAGE1) pv_d[2] = 1'b1;
        if (state_q == ST_STAGE2) pv_d[3] = 1'b1;
      end else begin
        if (hit && state_q == ST_STAGE3 && cool_q == '0) begin
          life_d = life_q - 2'd1;
          cool_d = CNT_W'(HIT_COOLDOWN);
          if (life_q == 2'd1) state_d = ST_FAIL;
        end
        // A lethal hit ends the stage, so progress events stop there.
        if (state_d == state_q) begin
          if (light_on && todo_q == TD_LIGHT)
            todo_d = TD_KEY;
          if (key_pick && todo_q == TD_KEY) begin
            if (key_q != 2'd3) key_d = key_q + 2'd1;
            if (key_q == 2'd2) todo_d = TD_DOOR;
          end
        end
      end
    end else if (click && guard_q == '0) begin
      unique case (1'b1)
        btn[B_STAGE1]: state_d = ST_STAGE1;
        btn[B_STAGE2]: state_d = ST_STAGE2;
        btn[B_STAGE3]: state_d = ST_STAGE3;
        btn[B_HELP]:   state_d = ST_HELP;
        btn[B_NEXT]:   state_d = (state_q == ST_SUCC3) ?
                         ST_STAFF : state_e'(state_q + 4'd1);
        btn[B_BACK]:   state_d = ST_TITLE;
        btn[B_RETRY]:  state_d = last_q;
        default:       state_d = state_q;
      endcase
    end
    if (state_d != state_q) begin
      guard_d = CNT_W'(CLICK_GUARD);
      if (is_stage(state_d)) begin
        key_d  = 2'd0;
        life_d = LIFE_INIT;
        cool_d = '0;
        last_d = state_d;
        todo_d = (state_d == ST_STAGE2) ? TD_LIGHT : TD_KEY;
      end else begin
        todo_d = TD_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_TITLE;
      last_q  <= ST_STAGE1;
      todo_q  <= TD_NONE;
      key_q   <= 2'd0;
      life_q  <= LIFE_INIT;
      pv_q    <= 4'b0010;
      guard_q <= CNT_W'(CLICK_GUARD);
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      todo_q  <= todo_d;
      key_q   <= key_d;
      life_q  <= life_d;
      pv_q    <= pv_d;
      guard_q <= guard_d;
      cool_q  <= cool_d;
    end
  end

  assign state      = state_q;
  assign key_find   = key_q;
  assign life       = life_q;
  assign todo       = todo_q;
  assign play_valid = pv_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed vector bench for game_flow_ctrl with short guard and
// cooldown so multi-cycle corners fit in a few hundred cycles.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       click = 1'b0;
  logic [8:0] click_x = '0;
  logic [8:0] click_y = '0;
  logic       key_pick = 1'b0;
  logic       light_on = 1'b0;
  logic       at_door = 1'b0;
  logic       hit = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] state;
  logic [1:0] key_find;
  logic [1:0] life;
  logic [1:0] todo;
  logic [3:0] play_valid;

  int n_cmp = 0;
  int n_bad = 0;

  game_flow_ctrl #(
    .CLICK_GUARD  (4),
    .HIT_COOLDOWN (8),
    .CNT_W        (27)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .click      (click),
    .click_x    (click_x),
    .click_y    (click_y),
    .key_pick   (key_pick),
    .light_on   (light_on),
    .at_door    (at_door),
    .hit        (hit),
    .abort      (abort),
    .state      (state),
    .key_find   (key_find),
    .life       (life),
    .todo       (todo),
    .play_valid (play_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pre;
    logic       c;
    logic [8:0] x;
    logic [8:0] y;
    logic       kp, lo, ad, ht, ab;
    logic [3:0] st;
    logic [1:0] k, l, t;
    logic [3:0] pv;
  } vec_t;

  vec_t vq[$];

  task automatic a(input int pre, c, x, y, kp, lo, ad, ht, ab,
                   input int st, k, l, t, pv);
    vec_t v;
    v.pre = pre; v.c = 1'(c);
    v.x = 9'(x); v.y = 9'(y);
    v.kp = 1'(kp); v.lo = 1'(lo); v.ad = 1'(ad);
    v.ht = 1'(ht); v.ab = 1'(ab);
    v.st = 4'(st); v.k = 2'(k); v.l = 2'(l);
    v.t = 2'(t); v.pv = 4'(pv);
    vq.push_back(v);
  endtask

  task automatic drive(input logic c, input int x, y,
                       input logic kp, lo, ad, ht, ab);
    click = c; click_x = 9'(x); click_y = 9'(y);
    key_pick = kp; light_on = lo; at_door = ad;
    hit = ht; abort = ab;
    @(posedge clk);
    #1;
    click = 0; key_pick = 0; light_on = 0;
    at_door = 0; hit = 0; abort = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string nm, input int st, k, l, t, pv);
    logic [13:0] got, exp;
    got = {state, key_find, life, todo, play_valid};
    exp = {4'(st), 2'(k), 2'(l), 2'(t), 4'(pv)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d key=%0d life=%0d todo=%0d pv=%b, want st=%0d key=%0d life=%0d todo=%0d pv=%b",
               nm, state, key_find, life, todo, play_valid,
               st, k, l, t, 4'(pv));
    end
  endtask

  initial begin
    // pre, click,x,y, kp,lo,ad,hit,ab, st,key,life,todo,pv
    a(5, 1,150,160, 0,0,0,0,0, 0,0,3,0,2);
    a(0, 1,150,130, 0,0,0,0,0, 2,0,3,1,2);
    a(1, 0,0,0,     1,0,0,0,0, 2,1,3,1,2);
    a(1, 0,0,0,     1,0,0,0,0, 2,2,3,1,2);
    a(1, 0,0,0,     1,0,0,0,0, 2,3,3,3,2);
    a(0, 0,0,0,     0,0,1,0,0, 3,3,3,0,6);
    a(5, 1,150,150, 0,0,0,0,0, 4,0,3,2,6);
    a(1, 0,0,0,     1,0,0,0,0, 4,0,3,2,6);
    a(1, 0,0,0,     0,1,0,0,0, 4,0,3,1,6);
    a(1, 0,0,0,     1,0,0,0,0, 4,1,3,1,6);
    a(1, 0,0,0,     1,0,0,0,0, 4,2,3,1,6);
    a(1, 0,0,0,     1,0,0,0,0, 4,3,3,3,6);
    a(0, 0,0,0,     0,0,1,0,0, 5,3,3,0,14);
    a(5, 1,150,150, 0,0,0,0,0, 6,0,3,1,14);
    a(0, 0,0,0,     0,0,0,1,0, 6,0,2,1,14);
    a(0, 0,0,0,     0,0,0,1,0, 6,0,2,1,14);
    a(0, 0,0,0,     0,0,0,1,0, 6,0,2,1,14);
    a(8, 0,0,0,     0,0,0,1,0, 6,0,1,1,14);
    a(10,0,0,0,     0,0,0,1,0, 8,0,0,0,14);
    a(5, 1,150,145, 0,0,0,0,0, 6,0,3,1,14);
    a(1, 0,0,0,     1,0,0,0,0, 6,1,3,1,14);
    a(1, 0,0,0,     1,0,0,0,0, 6,2,3,1,14);
    a(1, 0,0,0,     1,0,0,0,0, 6,3,3,3,14);
    a(0, 0,0,0,     0,0,0,1,0, 6,3,2,3,14);
    a(10,0,0,0,     0,0,0,1,0, 6,3,1,3,14);
    a(10,0,0,0,     0,0,1,1,0, 7,3,1,0,14);
    a(5, 1,150,155, 0,0,0,0,0, 1,3,1,0,14);
    a(5, 1,150,185, 0,0,0,0,0, 0,3,1,0,14);
    a(5, 1,200,215, 0,0,0,0,0, 0,3,1,0,14);
    a(0, 1,199,229, 0,0,0,0,0, 9,3,1,0,14);
    a(5, 1,150,220, 0,0,0,0,0, 9,3,1,0,14);
    a(0, 1,120,200, 0,0,0,0,0, 0,3,1,0,14);
    a(0, 1,150,130, 0,0,0,0,0, 0,3,1,0,14);
    a(5, 1,150,130, 0,0,0,0,0, 2,0,3,1,14);
    a(0, 0,0,0,     0,0,0,1,0, 2,0,3,1,14);
    a(0, 0,0,0,     0,0,0,0,1, 0,0,3,0,14);

    #2 rst_n = 1'b0;
    #1 check("reset", 0, 0, 3, 0, 2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vq[i]) begin
      idle(vq[i].pre);
      drive(vq[i].c, int'(vq[i].x), int'(vq[i].y), vq[i].kp,
            vq[i].lo, vq[i].ad, vq[i].ht, vq[i].ab);
      check($sformatf("vec%0d", i), int'(vq[i].st), int'(vq[i].k),
            int'(vq[i].l), int'(vq[i].t), int'(vq[i].pv));
    end

    idle(5);
    drive(1, 150, 160, 0, 0, 0, 0, 0);
    check("s2_enter", 4, 0, 3, 2, 14);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    check("s2_keys", 4, 2, 3, 1, 14);
    #3 rst_n = 1'b0;
    #1 check("async_rst", 0, 0, 3, 0, 2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    drive(1, 150, 160, 0, 0, 0, 0, 0);
    check("s2_locked", 0, 0, 3, 0, 2);
    drive(1, 150, 130, 0, 0, 0, 0, 0);
    check("s1_again", 2, 0, 3, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("abort", 0, 0, 3, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer that drives the UI overlay renderer's control inputs: screen `state`, `key_find`, `life`, `todo` and `play_valid`. It decodes mouse clicks against the fixed on-screen button rectangles and walks the title/help/stage/success/fail/staff screens. It also tracks in-stage objective progress from gameplay event pulses. It sits between the mouse/gameplay logic and the overlay renderer; all outputs are registered.

Parameters:
- CLICK_GUARD, 10_000_000: cycles after any screen change during which clicks are ignored (100 ms at 100 MHz).
- HIT_COOLDOWN, 100_000_000: cycles after a counted hit during which further hits are ignored.
- CNT_W, 27: width of the guard and cooldown counters; must hold max(CLICK_GUARD, HIT_COOLDOWN).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- click  in  1  one-cycle left-click pulse.
- click_x  in  9  click x in half-resolution coordinates (0..319).
- click_y  in  9  click y in half-resolution coordinates (0..239).
- key_pick  in  1  pulse: player picked up a key.
- light_on  in  1  pulse: player switched the light on.
- at_door  in  1  pulse: player reached the exit door.
- hit  in  1  pulse: player damaged.
- abort  in  1  pulse: escape to title.
- state  out  4  screen code: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8, HELP=9.
- key_find  out  2  keys collected, 0..3.
- life  out  2  remaining lives, 0..3.
- todo  out  2  current objective: NONE=0, FIND_KEY=1, FIND_LIGHT=2, FIND_DOOR=3.
- play_valid  out  4  stage unlock mask; bit k means stage k is selectable; bit 0 is unused and always 0.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - state=TITLE, key_find=0, life=3, todo=NONE, play_valid=4'b0010.
  - last_stage=STAGE1, guard counter loaded with CLICK_GUARD, cooldown counter=0.
- Timing: all outputs are registered. An input pulse sampled at edge N is visible at outputs after edge N.
- Click validity: a click is accepted only when the guard counter is 0.
  - Every state change reloads the guard counter to CLICK_GUARD.
  - Otherwise the guard counter decrements to 0 and saturates there.
- Button hit test: rectangles are half-open, [x0,x1) x [y0,y1).
  - All menu buttons below span x in [120,200).
- TITLE:
  - y [120,140) -> STAGE1.
  - y [150,170) -> STAGE2, only if play_valid[2]; otherwise the click is ignored.
  - y [180,200) -> STAGE3, only if play_valid[3]; otherwise the click is ignored.
  - y [210,230) -> HELP.
- HELP: y [200,220) -> TITLE.
- STAFF: y [180,200) -> TITLE.
- SUCCESS1 / SUCCESS2:
  - y [140,160) -> next stage (STAGE2 / STAGE3).
  - y [180,200) -> TITLE.
- SUCCESS3: y [150,170) -> STAFF.
- FAIL:
  - y [140,160) -> re-enter last_stage.
  - y [180,200) -> TITLE.
- Stage entry (any transition into STAGEk):
  - key_find=0, life=3, cooldown=0, last_stage=STAGEk.
  - todo=FIND_LIGHT for STAGE2; todo=FIND_KEY for STAGE1 and STAGE3.
- Leaving a stage: todo=NONE. key_find and life hold their last values; the renderer ignores them outside stages.
- In-stage events, evaluated each cycle in this priority order:
  1. abort -> TITLE; progress is discarded.
  2. at_door with todo==FIND_DOOR -> SUCCESSk, and play_valid[k+1] is set (k<3). Wins over a same-cycle lethal hit.
  3. hit, only in STAGE3 and only with cooldown==0:
     - life decrements and cooldown loads HIT_COOLDOWN.
     - If life was 1, go to FAIL.
     - In STAGE1 and STAGE2, hit is ignored.
  4. light_on with todo==FIND_LIGHT -> todo=FIND_KEY.
  5. key_pick with todo==FIND_KEY:
     - key_find increments, saturating at 3.
     - The increment that reaches 3 also sets todo=FIND_DOOR in the same cycle.
     - key_pick is ignored in any other todo.
- Independent events: key_pick and a non-lethal hit in the same cycle are both applied.
- Ignored inputs: clicks inside stages; gameplay pulses outside stages.
- play_valid persistence: bits are sticky until reset; they are never cleared by FAIL or abort.
- Cooldown counter: decrements to 0 whenever nonzero, in every state.

Decomposition:
- Package game_pkg:
  - state codes and todo codes;
  - button rectangle constants (x0, x1, y0 per button; all buttons are 20 rows tall);
  - reset life value 3.
- Sub-module ui_button_decode: combinational. Inputs are state, click_x, click_y and play_valid; output is a one-hot button id (STAGE1/2/3, HELP, NEXT, BACK, RETRY, NONE). The controller FSM instantiates it once.

Test Plan:
Benches set CLICK_GUARD=4 and HIT_COOLDOWN=8.
1. Reset, wait 5 cycles, click (150,160) -> state stays 0. Then click (150,130) -> state=2, todo=1, life=3, key_find=0.
2. In STAGE1, three key_pick pulses spaced by 2 cycles -> key_find 1,2,3 and todo=3 after the third. Then at_door -> state=3, play_valid=4'b0110.
3. Unlock through STAGE2: light_on first, then keys; a key_pick during FIND_LIGHT leaves key_find=0. Entering STAGE3 from SUCCESS2 with a click at (150,150) -> state=6, todo=1.
4. STAGE3 hit pulses on consecutive cycles -> life drops 3->2 only. After the cooldown expires, two more spaced hits -> life 1, then state=8. A click at (150,145) after the guard -> state=6, life=3.
5. STAGE3 with life=1: at_door (todo=3) and hit in the same cycle -> state=7, life stays 1. Click (150,155) -> state=1. Click (150,185) -> state=0.
6. rst_n asserted mid-STAGE2 with key_find=2 -> all outputs take reset values immediately (asynchronously), play_valid=4'b0010. Abort pulse in STAGE1 -> state=0.
